// File: rtl/core_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : core_seq_ctrl_if
// Brief    : Handshake bundle between the sequencer and IFU/EXU/LSU/WBU.
// Revision : 1.0 - initial release
// ============================================================================
interface core_seq_ctrl_if;
   logic [31:0] o_pc;
   logic        o_ifu_req;
   logic        i_ifu_valid;
   logic        i_is_mem;
   logic        o_exu_start;
   logic        i_exu_done;
   logic        o_lsu_req;
   logic        i_lsu_done;
   logic        o_wbu_valid;
   logic        i_wbu_ready;
   logic [31:0] i_pc_next;
   logic        i_ebreak;
   logic        o_retire;
   logic        o_halt;
   logic        o_timeout;
   logic [2:0]  o_state;

   modport master (
      output o_pc, o_ifu_req, o_exu_start, o_lsu_req, o_wbu_valid,
             o_retire, o_halt, o_timeout, o_state,
      input  i_ifu_valid, i_is_mem, i_exu_done, i_lsu_done, i_wbu_ready,
             i_pc_next, i_ebreak
   );

   modport slave (
      input  o_pc, o_ifu_req, o_exu_start, o_lsu_req, o_wbu_valid,
             o_retire, o_halt, o_timeout, o_state,
      output i_ifu_valid, i_is_mem, i_exu_done, i_lsu_done, i_wbu_ready,
             i_pc_next, i_ebreak
   );
endinterface
`default_nettype wire

// File: rtl/core_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : core_seq_ctrl
// Brief    : Multi-cycle FETCH/EXEC/MEM/WB sequencer owning the RV32 PC.
//            Optional bus-wait timeout enabled by macro SEQ_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module core_seq_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000,
   parameter int unsigned TIMEOUT  = 1024
) (
   input  wire logic       clock,
   input  wire logic       reset,
   core_seq_ctrl_if.master bus
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_EXEC  = 3'd2,
      S_MEM   = 3'd3,
      S_WB    = 3'd4,
      S_HALT  = 3'd5
   } state_t;

   state_t      state_q;
   logic [31:0] pc_q;
   logic        ifu_req_q;
   logic        exu_start_q;
   logic        lsu_req_q;
   logic        wbu_valid_q;
   logic        halt_q;
   logic        w_tmo_fire;

   if ((TIMEOUT < 2) || (TIMEOUT > 65535)) begin : g_timeout_range
      $fatal(1, "core_seq_ctrl: TIMEOUT out of range 2..65535");
   end

`ifdef SEQ_TIMEOUT_EN
   localparam logic [15:0] c_wait_last = 16'(TIMEOUT - 1);

   logic [15:0] wait_cnt_q;
   logic        timeout_q;
   logic        w_waiting;

   // Waiting means the consuming state sees no response this cycle.
   assign w_waiting  = ((state_q == S_FETCH) && !bus.i_ifu_valid) ||
                       ((state_q == S_MEM)   && !bus.i_lsu_done);
   assign w_tmo_fire = w_waiting && (wait_cnt_q == c_wait_last);

   always_ff @(posedge clock) begin
      if (reset) begin
         wait_cnt_q <= 16'd0;
         timeout_q  <= 1'b0;
      end else begin
         if (w_waiting && !w_tmo_fire) begin
            wait_cnt_q <= wait_cnt_q + 16'd1;
         end else begin
            wait_cnt_q <= 16'd0;
         end
         if (w_tmo_fire) begin
            timeout_q <= 1'b1;
         end
      end
   end

   assign bus.o_timeout = timeout_q;
`else
   assign w_tmo_fire    = 1'b0;
   assign bus.o_timeout = 1'b0;
`endif

   // Outputs are registered: every transition also loads the outputs of the
   // state being entered.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= S_IDLE;
         pc_q        <= RESET_PC;
         ifu_req_q   <= 1'b0;
         exu_start_q <= 1'b0;
         lsu_req_q   <= 1'b0;
         wbu_valid_q <= 1'b0;
         halt_q      <= 1'b0;
      end else begin
         exu_start_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               state_q   <= S_FETCH;
               ifu_req_q <= 1'b1;
            end
            S_FETCH: begin
               if (bus.i_ifu_valid) begin
                  state_q     <= S_EXEC;
                  ifu_req_q   <= 1'b0;
                  exu_start_q <= 1'b1;
               end else if (w_tmo_fire) begin
                  state_q   <= S_HALT;
                  ifu_req_q <= 1'b0;
                  halt_q    <= 1'b1;
               end
            end
            S_EXEC: begin
               if (bus.i_exu_done) begin
                  if (bus.i_is_mem) begin
                     state_q   <= S_MEM;
                     lsu_req_q <= 1'b1;
                  end else begin
                     state_q     <= S_WB;
                     wbu_valid_q <= 1'b1;
                  end
               end
            end
            S_MEM: begin
               if (bus.i_lsu_done) begin
                  state_q     <= S_WB;
                  lsu_req_q   <= 1'b0;
                  wbu_valid_q <= 1'b1;
               end else if (w_tmo_fire) begin
                  state_q   <= S_HALT;
                  lsu_req_q <= 1'b0;
                  halt_q    <= 1'b1;
               end
            end
            S_WB: begin
               if (bus.i_wbu_ready) begin
                  wbu_valid_q <= 1'b0;
                  if (bus.i_ebreak) begin
                     state_q <= S_HALT;
                     halt_q  <= 1'b1;
                  end else begin
                     state_q   <= S_FETCH;
                     pc_q      <= bus.i_pc_next;
                     ifu_req_q <= 1'b1;
                  end
               end
            end
            S_HALT: begin
               state_q <= S_HALT;
            end
            default: begin
               // Illegal encodings fall back to IDLE with everything quiet.
               state_q     <= S_IDLE;
               ifu_req_q   <= 1'b0;
               lsu_req_q   <= 1'b0;
               wbu_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.o_pc        = pc_q;
   assign bus.o_ifu_req   = ifu_req_q;
   assign bus.o_exu_start = exu_start_q;
   assign bus.o_lsu_req   = lsu_req_q;
   assign bus.o_wbu_valid = wbu_valid_q;
   assign bus.o_retire    = wbu_valid_q && bus.i_wbu_ready;
   assign bus.o_halt      = halt_q;
   assign bus.o_state     = state_q;

endmodule
`default_nettype wire

// File: tb/tb_core_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_core_seq_ctrl
// Brief    : Table-driven self-checking bench for core_seq_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_core_seq_ctrl;

`ifdef SEQ_TIMEOUT_EN
   localparam int unsigned TB_TIMEOUT = 8;
`else
   localparam int unsigned TB_TIMEOUT = 1024;
`endif
   localparam logic [31:0] RST = 32'h8000_0000;

   // in  = {rst, ifu_valid, exu_done, is_mem, lsu_done, wbu_ready, ebreak}
   // ret = {check, expected retire} in the cycle the inputs are applied
   // out = {ifu_req, exu_start, lsu_req, wbu_valid, halt, timeout} after the edge
   typedef struct {
      logic [6:0]  in;
      logic [31:0] pcn;
      logic [1:0]  ret;
      logic [2:0]  st;
      logic [31:0] pc;
      logic [5:0]  out;
   } vec_t;

   logic clock = 1'b0;
   logic reset = 1'b0;
   int   checks = 0;
   int   errors = 0;
   vec_t vt[$];
   vec_t sb[$];

   core_seq_ctrl_if bus();

   core_seq_ctrl #(
      .RESET_PC (RST),
      .TIMEOUT  (TB_TIMEOUT)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   function automatic vec_t mk(input logic [6:0] i, input logic [31:0] n, input logic [1:0] r,
                               input logic [2:0] s, input logic [31:0] p, input logic [5:0] o);
      vec_t t;
      t.in = i; t.pcn = n; t.ret = r; t.st = s; t.pc = p; t.out = o;
      return t;
   endfunction

   task automatic step(input vec_t t, input string name, input int idx);
      vec_t       e;
      logic [5:0] act;
      @(negedge clock);
      reset           = t.in[6];
      bus.i_ifu_valid = t.in[5];
      bus.i_exu_done  = t.in[4];
      bus.i_is_mem    = t.in[3];
      bus.i_lsu_done  = t.in[2];
      bus.i_wbu_ready = t.in[1];
      bus.i_ebreak    = t.in[0];
      bus.i_pc_next   = t.pcn;
      sb.push_back(t);
      #1;
      if (t.ret[1]) begin
         checks++;
         if (bus.o_retire !== t.ret[0]) begin
            errors++;
            $display("FAIL %s[%0d] retire: got %b expected %b", name, idx, bus.o_retire, t.ret[0]);
         end
      end
      @(posedge clock);
      #1;
      e   = sb.pop_front();
      act = {bus.o_ifu_req, bus.o_exu_start, bus.o_lsu_req, bus.o_wbu_valid, bus.o_halt, bus.o_timeout};
      checks++;
      if ({bus.o_state, bus.o_pc, act} !== {e.st, e.pc, e.out}) begin
         errors++;
         $display("FAIL %s[%0d]: got state=%0d pc=%h out=%b expected state=%0d pc=%h out=%b",
                  name, idx, bus.o_state, bus.o_pc, act, e.st, e.pc, e.out);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.i_ifu_valid = 1'b0; bus.i_exu_done = 1'b0; bus.i_is_mem = 1'b0;
      bus.i_lsu_done  = 1'b0; bus.i_wbu_ready = 1'b0; bus.i_ebreak = 1'b0;
      bus.i_pc_next   = 32'h0;

      // Reset, then two back-to-back non-memory instructions with zero-wait responders.
      vt.push_back(mk(7'b1000000, 32'h0,         2'b00, 3'd0, RST,           6'b000000));
      vt.push_back(mk(7'b0110010, 32'h8000_0004, 2'b10, 3'd1, RST,           6'b100000));
      vt.push_back(mk(7'b0110010, 32'h8000_0004, 2'b10, 3'd2, RST,           6'b010000));
      vt.push_back(mk(7'b0110010, 32'h8000_0004, 2'b10, 3'd4, RST,           6'b000100));
      vt.push_back(mk(7'b0110010, 32'h8000_0004, 2'b11, 3'd1, 32'h8000_0004, 6'b100000));
      vt.push_back(mk(7'b0110010, 32'h8000_0008, 2'b10, 3'd2, 32'h8000_0004, 6'b010000));
      vt.push_back(mk(7'b0110010, 32'h8000_0008, 2'b10, 3'd4, 32'h8000_0004, 6'b000100));
      vt.push_back(mk(7'b0110010, 32'h8000_0008, 2'b11, 3'd1, 32'h8000_0008, 6'b100000));
      // Load: lsu_done arrives on the sixth MEM cycle; stray valid/done ignored in MEM.
      vt.push_back(mk(7'b0111000, 32'h8000_000C, 2'b10, 3'd2, 32'h8000_0008, 6'b010000));
      vt.push_back(mk(7'b0111000, 32'h8000_000C, 2'b10, 3'd3, 32'h8000_0008, 6'b001000));
      for (int k = 0; k < 5; k++)
         vt.push_back(mk(7'b0111000, 32'h8000_000C, 2'b10, 3'd3, 32'h8000_0008, 6'b001000));
      vt.push_back(mk(7'b0111100, 32'h8000_000C, 2'b10, 3'd4, 32'h8000_0008, 6'b000100));
      vt.push_back(mk(7'b0000010, 32'h8000_000C, 2'b11, 3'd1, 32'h8000_000C, 6'b100000));
      // Branch: ready held low for two WB cycles (ebreak without ready is not a commit).
      vt.push_back(mk(7'b0100000, 32'h8000_0100, 2'b10, 3'd2, 32'h8000_000C, 6'b010000));
      vt.push_back(mk(7'b0010000, 32'h8000_0100, 2'b10, 3'd4, 32'h8000_000C, 6'b000100));
      vt.push_back(mk(7'b0000001, 32'h8000_0100, 2'b10, 3'd4, 32'h8000_000C, 6'b000100));
      vt.push_back(mk(7'b0000000, 32'h8000_0100, 2'b10, 3'd4, 32'h8000_000C, 6'b000100));
      vt.push_back(mk(7'b0000010, 32'h8000_0100, 2'b11, 3'd1, 32'h8000_0100, 6'b100000));
      // Fetch wait with stray lsu_done, then a two-cycle EXEC.
      vt.push_back(mk(7'b0000100, 32'h0,         2'b10, 3'd1, 32'h8000_0100, 6'b100000));
      vt.push_back(mk(7'b0000000, 32'h0,         2'b10, 3'd1, 32'h8000_0100, 6'b100000));
      vt.push_back(mk(7'b0100000, 32'h0,         2'b10, 3'd2, 32'h8000_0100, 6'b010000));
      vt.push_back(mk(7'b0000000, 32'h0,         2'b10, 3'd2, 32'h8000_0100, 6'b000000));
      vt.push_back(mk(7'b0010000, 32'h0,         2'b10, 3'd4, 32'h8000_0100, 6'b000100));
      // ebreak commit halts with PC frozen; everything else is ignored until reset.
      vt.push_back(mk(7'b0000011, 32'h8000_0200, 2'b11, 3'd5, 32'h8000_0100, 6'b000010));
      vt.push_back(mk(7'b0111110, 32'h8000_0200, 2'b10, 3'd5, 32'h8000_0100, 6'b000010));
      vt.push_back(mk(7'b0111110, 32'h8000_0200, 2'b10, 3'd5, 32'h8000_0100, 6'b000010));
      vt.push_back(mk(7'b1000000, 32'h0,         2'b10, 3'd0, RST,           6'b000000));
      // Reset in MEM together with lsu_done: the done is dropped.
      vt.push_back(mk(7'b0000000, 32'h0,         2'b10, 3'd1, RST,           6'b100000));
      vt.push_back(mk(7'b0100000, 32'h0,         2'b10, 3'd2, RST,           6'b010000));
      vt.push_back(mk(7'b0011000, 32'h0,         2'b10, 3'd3, RST,           6'b001000));
      vt.push_back(mk(7'b0000000, 32'h0,         2'b10, 3'd3, RST,           6'b001000));
      vt.push_back(mk(7'b1000100, 32'h0,         2'b10, 3'd0, RST,           6'b000000));
      vt.push_back(mk(7'b0000100, 32'h0,         2'b10, 3'd1, RST,           6'b100000));
      // Misaligned next PC is loaded unchanged.
      vt.push_back(mk(7'b0100000, 32'h8000_0103, 2'b10, 3'd2, RST,           6'b010000));
      vt.push_back(mk(7'b0010000, 32'h8000_0103, 2'b10, 3'd4, RST,           6'b000100));
      vt.push_back(mk(7'b0000010, 32'h8000_0103, 2'b11, 3'd1, 32'h8000_0103, 6'b100000));

      foreach (vt[i]) step(vt[i], "vec", i);

`ifdef SEQ_TIMEOUT_EN
      // Fetch never answered: eighth FETCH cycle halts with timeout.
      step(mk(7'b1000000, 32'h0, 2'b10, 3'd0, RST, 6'b000000), "tmo_rst", 0);
      step(mk(7'b0000000, 32'h0, 2'b10, 3'd1, RST, 6'b100000), "tmo_idle", 0);
      for (int k = 0; k < 7; k++)
         step(mk(7'b0000000, 32'h0, 2'b10, 3'd1, RST, 6'b100000), "tmo_wait", k);
      step(mk(7'b0000000, 32'h0, 2'b10, 3'd5, RST, 6'b000011), "tmo_fire", 0);
      step(mk(7'b0100000, 32'h0, 2'b10, 3'd5, RST, 6'b000011), "tmo_hold", 0);
      // Valid on the eighth cycle wins over the timeout.
      step(mk(7'b1000000, 32'h0, 2'b10, 3'd0, RST, 6'b000000), "tmo_rst", 1);
      step(mk(7'b0000000, 32'h0, 2'b10, 3'd1, RST, 6'b100000), "tmo_idle", 1);
      for (int k = 0; k < 7; k++)
         step(mk(7'b0000000, 32'h0, 2'b10, 3'd1, RST, 6'b100000), "tmo_wait2", k);
      step(mk(7'b0100000, 32'h0, 2'b10, 3'd2, RST, 6'b010000), "tmo_win", 0);
`else
      // Without the timeout a fetch may wait well past TIMEOUT cycles.
      for (int k = 0; k < 1100; k++)
         step(mk(7'b0000000, 32'h0, 2'b10, 3'd1, 32'h8000_0103, 6'b100000), "fetch_wait", k);
      step(mk(7'b0100000, 32'h0, 2'b10, 3'd2, 32'h8000_0103, 6'b010000), "fetch_late", 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
